// File: rtl/lcd_seq.sv
// HD44780 4-bit command sequencer in front of lcd_ctrl.
// Runs the power-up init, then issues requester bytes with fixed settle waits.
module lcd_seq #(
    parameter int POWERUP_CYCLES = 150000,
    parameter int BYTE_CYCLES    = 400,
    parameter int LONG_CYCLES    = 16400,
    parameter int CNT_W          = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       rs,
    output logic       rw,
    output logic [7:0] datain,
    output logic       start
);

    typedef enum logic [2:0] {
        PWRUP,
        INIT_ISSUE,
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [2:0]       idx_q, idx_n;
    logic             start_n, rs_n, ready_n, done_n;
    logic [7:0]       data_n;
    logic             long_wait;
    logic [CNT_W-1:0] wait_cnt;

    function automatic logic [7:0] rom(input logic [2:0] i);
        case (i)
            3'd0:    rom = 8'h33;
            3'd1:    rom = 8'h32;
            3'd2:    rom = 8'h28;
            3'd3:    rom = 8'h0C;
            3'd4:    rom = 8'h06;
            default: rom = 8'h01;
        endcase
    endfunction

    // clear/home commands need the long settle time
    assign long_wait = !rs && (datain == 8'h01 || datain == 8'h02 ||
                               datain == 8'h03);
    assign wait_cnt  = long_wait ? CNT_W'(LONG_CYCLES - 1)
                                 : CNT_W'(BYTE_CYCLES - 1);
    assign rw        = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= PWRUP;
            cnt_q     <= CNT_W'(POWERUP_CYCLES - 1);
            idx_q     <= 3'd0;
            start     <= 1'b0;
            rs        <= 1'b0;
            datain    <= 8'h00;
            req_ready <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            idx_q     <= idx_n;
            start     <= start_n;
            rs        <= rs_n;
            datain    <= data_n;
            req_ready <= ready_n;
            init_done <= done_n;
        end
    end

    // outputs are computed for the next state so they register cleanly
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        start_n = 1'b0;
        rs_n    = rs;
        data_n  = datain;
        ready_n = 1'b0;
        done_n  = init_done;
        case (state_q)
            PWRUP: begin
                if (cnt_q == '0) begin
                    state_n = INIT_ISSUE;
                    start_n = 1'b1;
                    rs_n    = 1'b0;
                    data_n  = rom(idx_q);
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            INIT_ISSUE, ISSUE: begin
                cnt_n   = wait_cnt;
                state_n = WAIT;
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - 1'b1;
                end else if (init_done) begin
                    state_n = IDLE;
                    ready_n = 1'b1;
                end else if (idx_q < 3'd5) begin
                    idx_n   = idx_q + 3'd1;
                    state_n = INIT_ISSUE;
                    start_n = 1'b1;
                    rs_n    = 1'b0;
                    data_n  = rom(idx_q + 3'd1);
                end else begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                    ready_n = 1'b1;
                end
            end
            IDLE: begin
                ready_n = 1'b1;
                if (req_valid) begin
                    state_n = ISSUE;
                    start_n = 1'b1;
                    rs_n    = req_rs;
                    data_n  = req_data;
                    ready_n = 1'b0;
                end
            end
            default: begin
                state_n = PWRUP;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_seq.sv
// Self-checking bench for lcd_seq against a cycle-schedule reference model.
module tb_lcd_seq;
    localparam int P = 4;
    localparam int B = 3;
    localparam int L = 8;
    localparam int INIT_END = P + 5 * (B + 1) + 1 + L;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_rs;
    logic [7:0] req_data;
    logic       req_ready, init_done, rs, rw, start;
    logic [7:0] datain;

    int tests = 0;
    int fails = 0;
    int cyc;
    int m_ready_at, m_start_at;
    logic       m_have, m_rs;
    logic [7:0] m_data;
    logic [7:0] rom [6] = '{8'h33, 8'h32, 8'h28, 8'h0C, 8'h06, 8'h01};

    lcd_seq #(
        .POWERUP_CYCLES(P),
        .BYTE_CYCLES   (B),
        .LONG_CYCLES   (L),
        .CNT_W         (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_rs   (req_rs),
        .req_data (req_data),
        .req_ready(req_ready),
        .init_done(init_done),
        .rs       (rs),
        .rw       (rw),
        .datain   (datain),
        .start    (start)
    );

    always #5 clk = ~clk;

    function automatic int dly(input logic r, input logic [7:0] d);
        return (!r && d >= 8'h01 && d <= 8'h03) ? L : B;
    endfunction

    task automatic cmp(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        cyc        = 0;
        m_have     = 1'b0;
        m_rs       = 1'b0;
        m_data     = 8'h00;
        m_start_at = -1;
        m_ready_at = INIT_END;
    endtask

    task automatic check_cycle();
        logic       e_start, e_rs;
        logic [7:0] e_data;
        int k;
        e_start = 1'b0;
        e_rs    = 1'b0;
        e_data  = 8'h00;
        if (cyc < INIT_END) begin
            if (cyc >= P) begin
                k       = (cyc - P) / (B + 1);
                e_start = ((cyc - P) % (B + 1) == 0) && k <= 5;
                e_data  = rom[(k > 5) ? 5 : k];
            end
        end else begin
            e_start = (cyc == m_start_at);
            e_rs    = m_have ? m_rs : 1'b0;
            e_data  = m_have ? m_data : 8'h01;
        end
        cmp("start", {7'd0, start}, {7'd0, e_start});
        cmp("rs", {7'd0, rs}, {7'd0, e_rs});
        cmp("datain", datain, e_data);
        cmp("rw", {7'd0, rw}, 8'd0);
        cmp("req_ready", {7'd0, req_ready}, {7'd0, cyc >= m_ready_at});
        cmp("init_done", {7'd0, init_done}, {7'd0, cyc >= INIT_END});
    endtask

    task automatic tick(input logic v, input logic r, input logic [7:0] d,
                        output logic acc);
        check_cycle();
        req_valid = v;
        req_rs    = r;
        req_data  = d;
        acc       = v && (cyc >= m_ready_at);
        @(posedge clk);
        if (acc) begin
            m_start_at = cyc + 1;
            m_have     = 1'b1;
            m_rs       = r;
            m_data     = d;
            m_ready_at = cyc + 2 + dly(r, d);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit noise);
        logic acc;
        for (int i = 0; i < n; i++) begin
            if (noise && cyc < m_ready_at)
                tick(1'($urandom % 2), 1'($urandom % 2), 8'($urandom), acc);
            else
                tick(1'b0, 1'b0, 8'h00, acc);
        end
    endtask

    task automatic send(input logic r, input logic [7:0] d);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++)
            tick(1'b1, r, d, acc);
        tests++;
        assert (acc) else begin
            fails++;
            $error("FAIL accept_timeout cyc=%0d got=0 exp=1", cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        cmp({tag, "_start"}, {7'd0, start}, 8'd0);
        cmp({tag, "_rs"}, {7'd0, rs}, 8'd0);
        cmp({tag, "_datain"}, datain, 8'd0);
        cmp({tag, "_ready"}, {7'd0, req_ready}, 8'd0);
        cmp({tag, "_done"}, {7'd0, init_done}, 8'd0);
    endtask

    initial begin
        logic acc;
        logic r;
        logic [7:0] d;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_rs    = 1'b0;
        req_data  = 8'h00;
        cyc       = 0;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        model_reset();
        idle(INIT_END + 2, 1'b1);

        send(1'b1, 8'hA5);
        idle(6, 1'b0);
        send(1'b0, 8'h01);
        send(1'b0, 8'h80);
        tick(1'b1, 1'b1, 8'hFF, acc);
        tick(1'b0, 1'b0, 8'h00, acc);
        idle(4, 1'b0);
        send(1'b1, 8'h01);
        idle(5, 1'b0);

        for (int i = 0; i < 12; i++) begin
            idle($urandom_range(0, 3), 1'b1);
            r = 1'($urandom % 2);
            d = ($urandom % 3 == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
            send(r, d);
        end
        idle(L + 3, 1'b1);

        send(1'b1, 8'h5A);
        tick(1'b0, 1'b0, 8'h00, acc);
        rst = 1'b1;
        #1;
        check_zero("midwait_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(INIT_END + 2, 1'b1);
        send(1'b1, 8'h3C);
        idle(B + 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
